// File: rtl/nios2_mult_cell_sched.sv
`timescale 1ns/1ps
// nios2_mult_cell_sched
// Two-requester scheduler for a shared three-product 16x16 multiplier cell.
// The cell produces p1=a_lo*b_lo, p2=a_lo*b_hi and p3=a_hi*b_lo, and registers
// them on clk while mul_en=1. The scheduler arbitrates round-robin, drives the
// cell operands and enable, waits MUL_LATENCY cycles per pass, and combines
// the partials into a 32-bit result:
//   MUL    (op=0) : low word of a*b, one cell pass
//   MULXUU (op=1) : high word of unsigned a*b, two passes (second gives a_hi*b_hi)
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   reqN_valid/ready          request handshake for requester N (N=0,1)
//   reqN_op, reqN_a, reqN_b   operation select and 32-bit operands
//   rsp_valid/ready           response handshake
//   rsp_id, rsp_data          owning requester and 32-bit result
//   busy                      high whenever an operation is in flight
//   mul_src1, mul_src2        cell operands (held between issues)
//   mul_en                    cell register enable (one cycle per issue)
//   mul_p1, mul_p2, mul_p3    cell partial products
module nios2_mult_cell_sched #(
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE1 = 3'd1,
    WAIT1  = 3'd2,
    ISSUE2 = 3'd3,
    WAIT2  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  // Counter runs from MUL_LATENCY-1 down to 0; the zero cycle is the capture cycle.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          rr_last;
  logic          op_q;
  logic          id_q;
  logic [15:0]   a_hi;
  logic [15:0]   b_hi;
  logic [31:0]   p1_q;
  logic [31:0]   p2_q;
  logic [31:0]   p3_q;
  logic [31:0]   hh_q;

  logic          any_valid;
  logic          grant_id;
  logic          take;
  logic          sel_op;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;

  logic [32:0]   mid;
  logic [32:0]   lo_sum;
  logic [31:0]   hi_word;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~rr_last;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    sel_op = grant_id ? req1_op : req0_op;
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
  end

  assign take       = (state == IDLE) && any_valid;
  assign req0_ready = take & ~grant_id;
  assign req1_ready = take &  grant_id;
  assign cnt_last   = (cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE1;
      ISSUE1:  state_nxt = WAIT1;
      WAIT1:   if (cnt_last) state_nxt = op_q ? ISSUE2 : DONE;
      ISSUE2:  state_nxt = WAIT2;
      WAIT2:   if (cnt_last) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      rr_last  <= 1'b1;
      op_q     <= 1'b0;
      id_q     <= 1'b0;
      a_hi     <= '0;
      b_hi     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
      hh_q     <= '0;
      mul_src1 <= '0;
      mul_src2 <= '0;
      mul_en   <= 1'b0;
    end else begin
      // Operands are registered one edge early so they are on the cell
      // exactly during the ISSUE cycle, and hold afterwards.
      mul_en <= (state_nxt == ISSUE1) || (state_nxt == ISSUE2);
      case (state)
        IDLE: begin
          if (take) begin
            op_q     <= sel_op;
            id_q     <= grant_id;
            rr_last  <= grant_id;
            a_hi     <= sel_a[31:16];
            b_hi     <= sel_b[31:16];
            mul_src1 <= sel_a;
            mul_src2 <= sel_b;
          end
        end
        ISSUE1, ISSUE2: begin
          cnt <= CNT_LOAD;
        end
        WAIT1: begin
          if (!cnt_last) begin
            cnt <= cnt - CW'(1);
          end else begin
            p1_q <= mul_p1;
            p2_q <= mul_p2;
            p3_q <= mul_p3;
            if (op_q) begin
              mul_src1 <= {16'h0000, a_hi};
              mul_src2 <= {16'h0000, b_hi};
            end
          end
        end
        WAIT2: begin
          if (!cnt_last) begin
            cnt <= cnt - CW'(1);
          end else begin
            hh_q <= mul_p1;
          end
        end
        default: ;
      endcase
    end
  end

  // P64 = {hh,p1} + (mid << 16); the high word takes the carry out of the low word.
  always_comb begin
    mid     = {1'b0, p2_q} + {1'b0, p3_q};
    lo_sum  = {1'b0, p1_q} + {1'b0, mid[15:0], 16'h0000};
    hi_word = hh_q + {15'h0000, mid[32:16]} + {31'h0, lo_sum[32]};
  end

  assign rsp_data  = op_q ? hi_word : lo_sum[31:0];
  assign rsp_valid = (state == DONE);
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule
